// File: rtl/viterbi_acs_pm.sv
// Add-compare-select and path-metric registers for the 4-state (7,5) K=3 decoder.
// Define ACS_PM_NORM_EN to enable MSB-clear metric normalization.
module viterbi_acs_pm #(
  parameter int PM_W    = 8,
  parameter int INIT_PM = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            init,
  input  logic            bm_valid,
  input  logic [1:0]      bm00,
  input  logic [1:0]      bm01,
  input  logic [1:0]      bm10,
  input  logic [1:0]      bm11,
  output logic            dec_valid,
  output logic [3:0]      dec,
  output logic [1:0]      best_state,
  output logic [PM_W-1:0] best_pm,
  output logic [PM_W-1:0] pm0,
  output logic [PM_W-1:0] pm1,
  output logic [PM_W-1:0] pm2,
  output logic [PM_W-1:0] pm3
);

  localparam int CW = PM_W + 1;
  localparam logic [CW-1:0] MAXV = {1'b0, {PM_W{1'b1}}};
  localparam logic [PM_W-1:0] INITV = PM_W'(INIT_PM);
  localparam logic [4*PM_W-1:0] PM_RST =
    {INITV, INITV, INITV, {PM_W{1'b0}}};

  // Branch codewords indexed by next state, n3 first
  localparam logic [3:0][1:0] CW_E = {2'b01, 2'b11, 2'b10, 2'b00};
  localparam logic [3:0][1:0] CW_O = {2'b10, 2'b00, 2'b01, 2'b11};

  logic [3:0][PM_W-1:0] pm_q, pm_d;
  logic [3:0]           dec_q, dec_d;
  logic [1:0]           bs_q, bs_d;
  logic [PM_W-1:0]      bpm_q, bpm_d;
  logic                 dv_q, dv_d;

  logic [3:0][1:0]      bm;
  logic [3:0][CW-1:0]   cand_e, cand_o, acs, norm;
  logic [3:0][PM_W-1:0] sat;
  logic [3:0]           sel;
  logic [1:0]           bi;
  logic [PM_W-1:0]      bv;
`ifdef ACS_PM_NORM_EN
  localparam logic [CW-1:0] HALF = CW'(1) << (PM_W - 1);
  logic                 all_hi;
`endif

  assign bm = {bm11, bm10, bm01, bm00};

  always_comb begin
    cand_e = '0;
    cand_o = '0;
    acs    = '0;
    sel    = '0;
    for (int n = 0; n < 4; n++) begin
      cand_e[n] = {1'b0, pm_q[2*(n%2)]}
                + CW'(bm[CW_E[n]]);
      cand_o[n] = {1'b0, pm_q[2*(n%2)+1]}
                + CW'(bm[CW_O[n]]);
      sel[n] = cand_o[n] < cand_e[n];
      acs[n] = sel[n] ? cand_o[n] : cand_e[n];
    end

    norm = acs;
`ifdef ACS_PM_NORM_EN
    all_hi = 1'b1;
    for (int n = 0; n < 4; n++)
      if (acs[n] < HALF) all_hi = 1'b0;
    if (all_hi)
      for (int n = 0; n < 4; n++)
        norm[n] = acs[n] - HALF;
`endif

    sat = '0;
    for (int n = 0; n < 4; n++)
      sat[n] = (norm[n] > MAXV) ? MAXV[PM_W-1:0]
                                : norm[n][PM_W-1:0];

    // Strict compare keeps the lowest index on ties
    bi = 2'd0;
    bv = sat[0];
    for (int n = 1; n < 4; n++) begin
      if (sat[n] < bv) begin
        bi = 2'(n);
        bv = sat[n];
      end
    end
  end

  always_comb begin
    pm_d  = pm_q;
    dec_d = dec_q;
    bs_d  = bs_q;
    bpm_d = bpm_q;
    dv_d  = 1'b0;
    if (init) begin
      pm_d = PM_RST;
    end else if (bm_valid) begin
      pm_d  = sat;
      dec_d = sel;
      bs_d  = bi;
      bpm_d = bv;
      dv_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pm_q  <= PM_RST;
      dec_q <= '0;
      bs_q  <= '0;
      bpm_q <= '0;
      dv_q  <= 1'b0;
    end else begin
      pm_q  <= pm_d;
      dec_q <= dec_d;
      bs_q  <= bs_d;
      bpm_q <= bpm_d;
      dv_q  <= dv_d;
    end
  end

  assign dec_valid  = dv_q;
  assign dec        = dec_q;
  assign best_state = bs_q;
  assign best_pm    = bpm_q;
  assign pm0        = pm_q[0];
  assign pm1        = pm_q[1];
  assign pm2        = pm_q[2];
  assign pm3        = pm_q[3];

endmodule
